// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared ALU.
// Grants one requester, holds its operation on the ALU handshake until
// alu_rdy, captures the results and pulses that requester's done.
// Optional feature macro: ALU_ARB_TIMEOUT_EN -- abandons an operation
// after TIMEOUT BUSY cycles without alu_rdy and reports it on err.

module alu_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [5:0]  op0,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic        req1,
    input  logic [5:0]  op1,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] res_lo,
    output logic [15:0] res_hi,
    output logic [3:0]  flags,
    output logic        err,
    output logic        busy,
    output logic        owner,
    output logic        alu_bgn,
    output logic [5:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_acc1,
    input  logic [15:0] alu_acc2,
    input  logic [3:0]  alu_flags,
    input  logic        alu_rdy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    logic   last_q;     // requester granted most recently (tie breaker)
    logic   grant_c;    // requester that would be granted this cycle

    // Round-robin choice: a tie goes to the requester that was not last served.
    assign grant_c = (req0 && req1) ? ~last_q : req1;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;  // BUSY cycles seen without alu_rdy
    logic             err_q;
    logic             tmo_c;

    assign tmo_c = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign err   = err_q;

    // Timeout counter and error pulse; cleared on every grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: cnt_q <= '0;
                BUSY: begin
                    if (alu_rdy) begin
                        cnt_q <= '0;
                    end else if (tmo_c) begin
                        cnt_q <= '0;
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end
`else
    logic tmo_c;

    assign tmo_c = 1'b0;
    assign err   = 1'b0;
`endif

    // Arbitration FSM with registered ALU handshake, results and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner   <= 1'b0;
            alu_bgn <= 1'b0;
            alu_op  <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            res_lo  <= '0;
            res_hi  <= '0;
            flags   <= '0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        owner   <= grant_c;
                        last_q  <= grant_c;
                        alu_op  <= grant_c ? op1 : op0;
                        alu_a   <= grant_c ? a1  : a0;
                        alu_b   <= grant_c ? b1  : b0;
                        alu_bgn <= 1'b1;
                        busy    <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (alu_rdy) begin
                        res_lo  <= alu_acc1;
                        res_hi  <= alu_acc2;
                        flags   <= alu_flags;
                        alu_bgn <= 1'b0;
                        done0   <= ~owner;
                        done1   <= owner;
                        state_q <= DONE;
                    end else if (tmo_c) begin
                        res_lo  <= '0;
                        res_hi  <= '0;
                        flags   <= '0;
                        alu_bgn <= 1'b0;
                        done0   <= ~owner;
                        done1   <= owner;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    alu_bgn <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model of grant order,
// handshake timing and captured results, with randomized operations.

module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [5:0]  op0, op1;
    logic [15:0] a0, b0, a1, b1;
    logic        done0, done1;
    logic [15:0] res_lo, res_hi;
    logic [3:0]  flags;
    logic        err, busy, owner;
    logic        alu_bgn;
    logic [5:0]  alu_op;
    logic [15:0] alu_a, alu_b;
    logic [15:0] alu_acc1, alu_acc2;
    logic [3:0]  alu_flags;
    logic        alu_rdy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic        m_last;
    logic [15:0] m_lo, m_hi;
    logic [3:0]  m_flags;

    alu_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .done0(done0), .done1(done1),
        .res_lo(res_lo), .res_hi(res_hi), .flags(flags),
        .err(err), .busy(busy), .owner(owner),
        .alu_bgn(alu_bgn), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_acc1(alu_acc1), .alu_acc2(alu_acc2), .alu_flags(alu_flags),
        .alu_rdy(alu_rdy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural ALU: {flags, acc2, acc1}; odd opcodes subtract, even add.
    function automatic logic [35:0] alu_fn(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r1, r2;
        s  = op[0] ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        r1 = s[15:0];
        r2 = (a & b) ^ {10'd0, op};
        return {(r1 == 16'd0), r1[15], s[16], 1'b0, r2, r1};
    endfunction

    task automatic randomize_ops();
        op0 = 6'($urandom); a0 = 16'($urandom); b0 = 16'($urandom);
        op1 = 6'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
    endtask

    // One full operation: request, d BUSY cycles without rdy, completion, done, back to IDLE.
    task automatic do_op(input bit r0, input bit r1, input int d, input bit mutate,
                         input bit drop_mid, input bit hold);
        logic        g;
        logic [5:0]  e_op;
        logic [15:0] e_a, e_b;
        logic [35:0] res;
        logic [1:0]  e_done;
        g    = (r0 && r1) ? ~m_last : r1;
        e_op = g ? op1 : op0;
        e_a  = g ? a1 : a0;
        e_b  = g ? b1 : b0;
        req0 = r0;
        req1 = r1;
        tick();
        check_eq("grant_bgn", 32'(alu_bgn), 32'd1);
        check_eq("grant_busy", 32'(busy), 32'd1);
        check_eq("grant_owner", 32'(owner), 32'(g));
        check_eq("grant_op", 32'(alu_op), 32'(e_op));
        check_eq("grant_a", 32'(alu_a), 32'(e_a));
        check_eq("grant_b", 32'(alu_b), 32'(e_b));
        m_last = g;
        if (mutate) randomize_ops();
        if (drop_mid) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
        for (int i = 0; i < d; i++) begin
            tick();
            check_eq("wait_bgn", 32'(alu_bgn), 32'd1);
            check_eq("wait_stable", {10'd0, alu_op, alu_a}, {10'd0, e_op, e_a});
            check_eq("wait_b", 32'(alu_b), 32'(e_b));
            check_eq("wait_nodone", 32'({done1, done0}), 32'd0);
        end
        res       = alu_fn(e_op, e_a, e_b);
        alu_acc1  = res[15:0];
        alu_acc2  = res[31:16];
        alu_flags = res[35:32];
        alu_rdy   = 1'b1;
        tick();
        e_done = g ? 2'b10 : 2'b01;
        m_lo = res[15:0]; m_hi = res[31:16]; m_flags = res[35:32];
        check_eq("done_pulse", 32'({done1, done0}), 32'(e_done));
        check_eq("done_lo", 32'(res_lo), 32'(m_lo));
        check_eq("done_hi", 32'(res_hi), 32'(m_hi));
        check_eq("done_flags", 32'(flags), 32'(m_flags));
        check_eq("done_bgn", 32'(alu_bgn), 32'd0);
        check_eq("done_busy", 32'(busy), 32'd1);
        check_eq("done_err", 32'(err), 32'd0);
        // Optionally leave a stray rdy with new data asserted during DONE.
        if ($urandom_range(0, 1) == 1) begin
            alu_acc1 = 16'($urandom); alu_acc2 = 16'($urandom); alu_flags = 4'($urandom);
        end else begin
            alu_rdy = 1'b0;
        end
        if (!hold) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
        tick();
        alu_rdy = 1'b0;
        check_eq("idle_done", 32'({done1, done0}), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_bgn", 32'(alu_bgn), 32'd0);
        check_eq("idle_lo", 32'(res_lo), 32'(m_lo));
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        op0 = '0; a0 = '0; b0 = '0; op1 = '0; a1 = '0; b1 = '0;
        alu_acc1 = '0; alu_acc2 = '0; alu_flags = '0; alu_rdy = 1'b0;
        m_last = 1'b1; m_lo = '0; m_hi = '0; m_flags = '0;
        tick();
        tick();
        check_eq("rst_bgn", 32'(alu_bgn), 32'd0);
        check_eq("rst_alu", {10'd0, alu_op, alu_a}, 32'd0);
        check_eq("rst_res", {res_hi, res_lo}, 32'd0);
        check_eq("rst_flags", 32'(flags), 32'd0);
        check_eq("rst_status", 32'({done1, done0, err, busy, owner}), 32'd0);
        rst = 1'b0;
        tick();
        check_eq("post_rst_busy", 32'(busy), 32'd0);

        // Tie from reset, each requester dropping at its own done: 0 then 1.
        randomize_ops();
        do_op(1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0);
        check_eq("tie_first", 32'(owner), 32'd0);
        do_op(1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        check_eq("tie_second", 32'(owner), 32'd1);

        // Both held continuously: alternating grants.
        for (int i = 0; i < 4; i++) begin
            randomize_ops();
            do_op(1'b1, 1'b1, $urandom_range(0, 7), 1'b0, 1'b0, 1'b1);
            check_eq("alt_owner", 32'(owner), 32'(i % 2));
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Single request 5+3 with rdy after bgn; then operand change while BUSY.
        op0 = 6'b000010; a0 = 16'd5; b0 = 16'd3;
        do_op(1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0);
        check_eq("add_res", 32'(res_lo), 32'd8);
        op0 = 6'b000010; a0 = 16'd5; b0 = 16'd3;
        do_op(1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        check_eq("stable_res", 32'(res_lo), 32'd8);

        // Stray rdy in IDLE is ignored.
        alu_rdy = 1'b1; alu_acc1 = 16'hdead; alu_acc2 = 16'hbeef; alu_flags = 4'hf;
        tick();
        tick();
        alu_rdy = 1'b0;
        check_eq("stray_done", 32'({done1, done0}), 32'd0);
        check_eq("stray_res", {res_hi, res_lo}, {m_hi, m_lo});
        check_eq("stray_flags", 32'(flags), 32'(m_flags));
        check_eq("stray_busy", 32'(busy), 32'd0);

        // Reset at BUSY cycle 2: operation abandoned, pointers back to reset values.
        randomize_ops();
        req0 = 1'b1; req1 = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        tick();
        rst = 1'b0;
        m_last = 1'b1; m_lo = '0; m_hi = '0; m_flags = '0;
        check_eq("midrst_bgn", 32'(alu_bgn), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_owner", 32'(owner), 32'd0);
        check_eq("midrst_done", 32'({done1, done0}), 32'd0);
        tick();
        check_eq("midrst_nodone", 32'({done1, done0}), 32'd0);
        randomize_ops();
        do_op(1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        check_eq("midrst_tie", 32'(owner), 32'd0);

`ifdef ALU_ARB_TIMEOUT_EN
        // ALU never responds: bgn held for 8 BUSY cycles, then done with err.
        randomize_ops();
        req0 = 1'b1;
        tick();
        req0 = 1'b0;
        m_last = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check_eq("tmo_wait_bgn", 32'(alu_bgn), 32'd1);
        end
        tick();
        m_lo = '0; m_hi = '0; m_flags = '0;
        check_eq("tmo_bgn", 32'(alu_bgn), 32'd0);
        check_eq("tmo_done", 32'({done1, done0}), 32'd1);
        check_eq("tmo_err", 32'(err), 32'd1);
        check_eq("tmo_res", {res_hi, res_lo}, 32'd0);
        check_eq("tmo_flags", 32'(flags), 32'd0);
        tick();
        check_eq("tmo_err_clr", 32'(err), 32'd0);
        check_eq("tmo_idle", 32'(busy), 32'd0);
`else
        // ALU never responds: the block waits indefinitely with err low.
        randomize_ops();
        req0 = 1'b1;
        tick();
        req0 = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check_eq("hang_busy", 32'(busy), 32'd1);
        check_eq("hang_bgn", 32'(alu_bgn), 32'd1);
        check_eq("hang_err", 32'(err), 32'd0);
        check_eq("hang_nodone", 32'({done1, done0}), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_last = 1'b1; m_lo = '0; m_hi = '0; m_flags = '0;
`endif
        tick();

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            bit r0, r1;
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1'b1;
            randomize_ops();
            do_op(r0, r1, $urandom_range(0, 7), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
